// File: rtl/hartslag_bewaking_if.sv
// Heart-rate monitor bus: per-window beat counts in, averaged rate and status out.
interface hartslag_bewaking_if;
    logic       count_valid;
    logic [7:0] count_in;
    logic       out_valid;
    logic [9:0] bpm;
    logic [2:0] status;
    logic       alarm;

    modport master (
        output count_valid,
        output count_in,
        input  out_valid,
        input  bpm,
        input  status,
        input  alarm
    );

    modport slave (
        input  count_valid,
        input  count_in,
        output out_valid,
        output bpm,
        output status,
        output alarm
    );
endinterface

// File: rtl/hartslag_bewaking.sv
// Heart-rate monitor: 4-sample moving average of beat counts, scaled to BPM,
// with confirmed LOW/HIGH classification, hysteresis and loss-of-signal detection.
// Stage 1 updates the history on the sampling edge; stage 2 evaluates one edge later.
module hartslag_bewaking #(
    parameter int MULT    = 4,
    parameter int LOW_TH  = 100,
    parameter int HIGH_TH = 180,
    parameter int HYST    = 10,
    parameter int CONFIRM = 3
) (
    input logic                clk,
    input logic                reset,
    hartslag_bewaking_if.slave bus
);

    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_NORMAL = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_LOST   = 3'd4
    } state_t;

    // Thresholds widened by one bit so the comparisons against bpm never wrap.
    localparam logic [10:0] LOW_ENTER  = 11'(LOW_TH);
    localparam logic [10:0] LOW_EXIT   = 11'(LOW_TH + HYST);
    localparam logic [10:0] HIGH_ENTER = 11'(HIGH_TH);
    localparam logic [10:0] HIGH_EXIT  = 11'(HIGH_TH - HYST);
    localparam logic [2:0]  CONF_N     = 3'(CONFIRM);

    logic [7:0]  hist [4];
    logic [9:0]  sum;
    logic [2:0]  fill;
    logic        zero_prev;

    logic        pend_valid;
    logic        pend_lost;
    logic        pend_flush;

    logic        sample_zero;
    logic        lost_hit;
    logic        lost_now;
    logic [9:0]  oldest;
    logic [9:0]  sum_shift;
    logic [2:0]  fill_inc;
    logic [9:0]  bpm_calc;
    logic [10:0] bpm_ext;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  conf;
    logic [2:0]  conf_nxt;
    logic [2:0]  run_len;
    logic        conf_high;
    logic        conf_high_nxt;
    logic [9:0]  bpm_reg;
    logic [9:0]  bpm_nxt;
    logic        out_valid;
    logic        out_valid_nxt;
    logic        alarm;
    logic        alarm_nxt;

    // Sample-side helpers; lost_now looks through a pending evaluation so a
    // recovery sample arriving right behind the second zero is still recognised.
    always_comb begin
        sample_zero = (bus.count_in == 8'd0);
        lost_hit    = sample_zero && zero_prev;
        lost_now    = pend_valid ? pend_lost : (state == ST_LOST);
        oldest      = (fill == 3'd4) ? {2'b00, hist[3]} : 10'd0;
        sum_shift   = sum + {2'b00, bus.count_in} - oldest;
        fill_inc    = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        bpm_calc    = 10'({2'b00, sum[9:2]} * MULT);
        bpm_ext     = {1'b0, bpm_calc};
    end

    // Stage 1: history, running sum, fill level and zero-run tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist[i] <= 8'd0;
            end
            sum        <= 10'd0;
            fill       <= 3'd0;
            zero_prev  <= 1'b0;
            pend_valid <= 1'b0;
            pend_lost  <= 1'b0;
            pend_flush <= 1'b0;
        end else begin
            pend_valid <= bus.count_valid;
            pend_lost  <= 1'b0;
            pend_flush <= 1'b0;
            if (bus.count_valid) begin
                zero_prev <= sample_zero;
                if (!lost_hit && lost_now) begin
                    hist[0]    <= bus.count_in;
                    hist[1]    <= 8'd0;
                    hist[2]    <= 8'd0;
                    hist[3]    <= 8'd0;
                    sum        <= {2'b00, bus.count_in};
                    fill       <= 3'd1;
                    pend_flush <= 1'b1;
                end else begin
                    hist[0]   <= bus.count_in;
                    hist[1]   <= hist[0];
                    hist[2]   <= hist[1];
                    hist[3]   <= hist[2];
                    sum       <= sum_shift;
                    fill      <= fill_inc;
                    pend_lost <= lost_hit;
                end
            end
        end
    end

    // Stage 2 next-state: classify the fresh average and run the confirm counter.
    always_comb begin
        state_nxt     = state;
        conf_nxt      = conf;
        conf_high_nxt = conf_high;
        bpm_nxt       = bpm_reg;
        out_valid_nxt = 1'b0;
        run_len       = 3'd0;
        if (pend_valid) begin
            if (pend_lost) begin
                state_nxt     = ST_LOST;
                conf_nxt      = 3'd0;
                out_valid_nxt = 1'b1;
            end else if (pend_flush) begin
                state_nxt = ST_WARMUP;
                conf_nxt  = 3'd0;
            end else if (fill == 3'd4) begin
                bpm_nxt       = bpm_calc;
                out_valid_nxt = 1'b1;
                case (state)
                    ST_WARMUP: begin
                        state_nxt = ST_NORMAL;
                        conf_nxt  = 3'd0;
                    end
                    ST_NORMAL: begin
                        if (bpm_ext < LOW_ENTER) begin
                            run_len = (conf != 3'd0 && !conf_high) ? conf + 3'd1 : 3'd1;
                            if (run_len >= CONF_N) begin
                                state_nxt = ST_LOW;
                                conf_nxt  = 3'd0;
                            end else begin
                                conf_nxt      = run_len;
                                conf_high_nxt = 1'b0;
                            end
                        end else if (bpm_ext > HIGH_ENTER) begin
                            run_len = (conf != 3'd0 && conf_high) ? conf + 3'd1 : 3'd1;
                            if (run_len >= CONF_N) begin
                                state_nxt = ST_HIGH;
                                conf_nxt  = 3'd0;
                            end else begin
                                conf_nxt      = run_len;
                                conf_high_nxt = 1'b1;
                            end
                        end else begin
                            conf_nxt = 3'd0;
                        end
                    end
                    ST_LOW: begin
                        if (bpm_ext >= LOW_EXIT) begin
                            run_len = conf + 3'd1;
                            if (run_len >= CONF_N) begin
                                state_nxt = ST_NORMAL;
                                conf_nxt  = 3'd0;
                            end else begin
                                conf_nxt = run_len;
                            end
                        end else begin
                            conf_nxt = 3'd0;
                        end
                    end
                    ST_HIGH: begin
                        if (bpm_ext <= HIGH_EXIT) begin
                            run_len = conf + 3'd1;
                            if (run_len >= CONF_N) begin
                                state_nxt = ST_NORMAL;
                                conf_nxt  = 3'd0;
                            end else begin
                                conf_nxt = run_len;
                            end
                        end else begin
                            conf_nxt = 3'd0;
                        end
                    end
                    default: begin
                        conf_nxt = 3'd0;
                    end
                endcase
            end
        end
        alarm_nxt = (state_nxt == ST_LOW) || (state_nxt == ST_HIGH) || (state_nxt == ST_LOST);
    end

    // Stage 2 registers: state, confirm counter and all visible outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_WARMUP;
            conf      <= 3'd0;
            conf_high <= 1'b0;
            bpm_reg   <= 10'd0;
            out_valid <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state     <= state_nxt;
            conf      <= conf_nxt;
            conf_high <= conf_high_nxt;
            bpm_reg   <= bpm_nxt;
            out_valid <= out_valid_nxt;
            alarm     <= alarm_nxt;
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.bpm       = bpm_reg;
    assign bus.status    = state;
    assign bus.alarm     = alarm;

endmodule

// File: tb/tb_hartslag_bewaking.sv
// Self-checking bench for hartslag_bewaking: directed scenarios followed by
// randomized beat-count streams, all checked against a per-sample reference model.
module tb_hartslag_bewaking;

    localparam int MULT     = 4;
    localparam int LOW_TH   = 100;
    localparam int HIGH_TH  = 180;
    localparam int HYST     = 10;
    localparam int CONFIRM  = 3;

    localparam int S_WARMUP = 0;
    localparam int S_NORMAL = 1;
    localparam int S_LOW    = 2;
    localparam int S_HIGH   = 3;
    localparam int S_LOST   = 4;

    logic clk = 1'b0;
    logic reset;

    hartslag_bewaking_if bus ();

    hartslag_bewaking #(
        .MULT    (MULT),
        .LOW_TH  (LOW_TH),
        .HIGH_TH (HIGH_TH),
        .HYST    (HYST),
        .CONFIRM (CONFIRM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: logical state after every accepted sample.
    int hq[$];
    int m_status;
    int streak;
    int kind;
    int l_bpm;
    bit zero_prev;

    // Outputs the DUT should currently show, and the outcome still in flight.
    bit e_valid;
    bit e_alarm;
    int e_bpm;
    int e_status;
    bit p_have;
    bit p_pulse;
    bit p_alarm;
    int p_bpm;
    int p_status;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        m_status  = S_WARMUP;
        streak    = 0;
        kind      = 0;
        l_bpm     = 0;
        zero_prev = 1'b0;
        e_valid   = 1'b0;
        e_alarm   = 1'b0;
        e_bpm     = 0;
        e_status  = S_WARMUP;
        p_have    = 1'b0;
        p_pulse   = 1'b0;
    endtask

    task automatic push_count(input int c);
        hq.push_front(c);
        if (hq.size() > 4) void'(hq.pop_back());
    endtask

    // Apply the rules to one accepted sample; result becomes visible one edge later.
    task automatic model_sample(input int c);
        bit lost_hit;
        int total;
        int b;
        lost_hit  = (c == 0) && zero_prev;
        zero_prev = (c == 0);
        p_pulse   = 1'b0;
        if (lost_hit) begin
            push_count(c);
            m_status = S_LOST;
            streak   = 0;
            p_pulse  = 1'b1;
        end else if (m_status == S_LOST) begin
            hq.delete();
            hq.push_front(c);
            m_status = S_WARMUP;
            streak   = 0;
        end else begin
            push_count(c);
            if (hq.size() == 4) begin
                total = 0;
                foreach (hq[i]) total += hq[i];
                b       = (total / 4) * MULT;
                l_bpm   = b;
                p_pulse = 1'b1;
                case (m_status)
                    S_WARMUP: begin
                        m_status = S_NORMAL;
                        streak   = 0;
                    end
                    S_NORMAL: begin
                        if (b < LOW_TH) begin
                            if (kind != 1) streak = 0;
                            kind = 1;
                            streak++;
                            if (streak >= CONFIRM) begin
                                m_status = S_LOW;
                                streak   = 0;
                            end
                        end else if (b > HIGH_TH) begin
                            if (kind != 2) streak = 0;
                            kind = 2;
                            streak++;
                            if (streak >= CONFIRM) begin
                                m_status = S_HIGH;
                                streak   = 0;
                            end
                        end else begin
                            streak = 0;
                        end
                    end
                    S_LOW: begin
                        if (b >= LOW_TH + HYST) begin
                            streak++;
                            if (streak >= CONFIRM) begin
                                m_status = S_NORMAL;
                                streak   = 0;
                            end
                        end else begin
                            streak = 0;
                        end
                    end
                    S_HIGH: begin
                        if (b <= HIGH_TH - HYST) begin
                            streak++;
                            if (streak >= CONFIRM) begin
                                m_status = S_NORMAL;
                                streak   = 0;
                            end
                        end else begin
                            streak = 0;
                        end
                    end
                    default: streak = 0;
                endcase
            end
        end
        p_bpm    = l_bpm;
        p_status = m_status;
        p_alarm  = (m_status == S_LOW) || (m_status == S_HIGH) || (m_status == S_LOST);
    endtask

    task automatic model_edge(input bit v, input int c);
        e_valid = 1'b0;
        if (p_have) begin
            e_valid  = p_pulse;
            e_bpm    = p_bpm;
            e_status = p_status;
            e_alarm  = p_alarm;
        end
        p_have = v;
        if (v) model_sample(c);
    endtask

    task automatic check_output(input string tag);
        cmp({tag, "_out_valid"}, 32'(bus.out_valid), 32'(e_valid));
        cmp({tag, "_bpm"},       32'(bus.bpm),       e_bpm);
        cmp({tag, "_status"},    32'(bus.status),    e_status);
        cmp({tag, "_alarm"},     32'(bus.alarm),     32'(e_alarm));
    endtask

    // One clock: check the settled outputs at the falling edge, then drive and clock.
    task automatic apply_stimulus(input bit v, input int c);
        @(negedge clk);
        check_output("cycle");
        bus.count_valid = v;
        bus.count_in    = 8'(c);
        @(posedge clk);
        model_edge(v, c);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset           = 1'b1;
        bus.count_valid = 1'b0;
        #1;
        cmp({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        cmp({tag, "_bpm"},       32'(bus.bpm),       0);
        cmp({tag, "_status"},    32'(bus.status),    S_WARMUP);
        cmp({tag, "_alarm"},     32'(bus.alarm),     0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic feed(input int c, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            apply_stimulus(1'b1, c);
            if (gap) apply_stimulus(1'b0, 0);
        end
    endtask

    task automatic settle();
        repeat (3) apply_stimulus(1'b0, 0);
    endtask

    task automatic expect_state(input string tag, input int st, input int al);
        #1;
        cmp({tag, "_status"}, 32'(bus.status), st);
        cmp({tag, "_alarm"},  32'(bus.alarm),  al);
    endtask

    task automatic expect_full(input string tag, input int v, input int b, input int st, input int al);
        #1;
        cmp({tag, "_out_valid"}, 32'(bus.out_valid), v);
        cmp({tag, "_bpm"},       32'(bus.bpm),       b);
        cmp({tag, "_status"},    32'(bus.status),    st);
        cmp({tag, "_alarm"},     32'(bus.alarm),     al);
    endtask

    initial begin
        reset           = 1'b1;
        bus.count_valid = 1'b0;
        bus.count_in    = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset("por");

        $display("[TB] warm-up with four counts of 35");
        feed(35, 4, 1'b0);
        apply_stimulus(1'b0, 0);
        expect_full("warmup_140", 1, 140, S_NORMAL, 0);
        settle();

        $display("[TB] low-rate entry and exit");
        feed(20, 8, 1'b1);
        settle();
        expect_state("low_entry", S_LOW, 1);
        feed(35, 8, 1'b0);
        settle();
        expect_state("low_exit", S_NORMAL, 0);

        $display("[TB] high-rate entry, hysteresis hold and exit");
        feed(50, 8, 1'b0);
        settle();
        expect_state("high_entry", S_HIGH, 1);
        feed(44, 6, 1'b1);
        settle();
        expect_state("high_hold", S_HIGH, 1);
        feed(40, 8, 1'b0);
        settle();
        expect_state("high_exit", S_NORMAL, 0);

        $display("[TB] loss of signal and recovery");
        feed(0, 2, 1'b0);
        settle();
        expect_state("lost_entry", S_LOST, 1);
        feed(30, 1, 1'b0);
        settle();
        expect_state("lost_recover", S_WARMUP, 0);
        feed(30, 3, 1'b1);
        settle();
        expect_state("rewarm", S_NORMAL, 0);

        $display("[TB] back-to-back counts 10,20,30,40");
        do_reset("b2b_reset");
        apply_stimulus(1'b1, 10);
        apply_stimulus(1'b1, 20);
        apply_stimulus(1'b1, 30);
        apply_stimulus(1'b1, 40);
        apply_stimulus(1'b0, 0);
        expect_full("b2b_100", 1, 100, S_NORMAL, 0);
        settle();

        $display("[TB] reset with an evaluation pending");
        apply_stimulus(1'b1, 35);
        do_reset("mid_reset");
        settle();

        $display("[TB] randomized count streams");
        for (int blk = 0; blk < 250; blk++) begin
            int base;
            int n;
            int c;
            if ($urandom_range(0, 39) == 0) do_reset("rnd_reset");
            case ($urandom_range(0, 7))
                0:       base = 18;
                1:       base = 26;
                2:       base = 35;
                3:       base = 43;
                4:       base = 52;
                5:       base = 0;
                6:       base = 250;
                default: base = 30;
            endcase
            n = int'($urandom_range(1, 8));
            for (int k = 0; k < n; k++) begin
                if (base == 0) c = 0;
                else c = base + int'($urandom_range(0, 6)) - 3;
                apply_stimulus(1'b1, c);
                if ($urandom_range(0, 2) == 0) apply_stimulus(1'b0, int'($urandom_range(0, 255)));
            end
        end
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
